count_step_monitor: RTL

COUNT_STEP_MONITOR -- requirements
Module: count_step_monitor

---
 rtl/count_step_monitor_if.sv | 29 ++
 rtl/count_step_monitor.sv | 116 +++++++++++
 2 files changed

// File: rtl/count_step_monitor_if.sv
// Bus between an up/down counter and its step monitor.
// master: drives q_in, up_down, clr_err and observes the monitor results.
// slave : the monitor; it samples the counter side and drives the event,
//         count and error outputs.
interface count_step_monitor_if #(
    parameter int unsigned WRAP_W = 8
);
    logic [1:0]        q_in;
    logic              up_down;
    logic              clr_err;
    logic              step_up;
    logic              step_dn;
    logic              wrap_up;
    logic              wrap_dn;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              stalled;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output q_in, up_down, clr_err,
        input  step_up, step_dn, wrap_up, wrap_dn, wrap_cnt, stalled, err, err_code
    );

    modport slave (
        input  q_in, up_down, clr_err,
        output step_up, step_dn, wrap_up, wrap_dn, wrap_cnt, stalled, err, err_code
    );
endinterface

// File: rtl/count_step_monitor.sv
// Watches a 2-bit up/down counter and reports legal steps, wraps, the net
// wrap count, stalls, and the first illegal jump or direction mismatch.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous active-low reset
//   bus   - count_step_monitor_if.slave (q_in, up_down, clr_err in;
//           step/wrap pulses, wrap_cnt, stalled, err, err_code out)
// All outputs are registered; events appear the cycle after the edge that
// samples the changed q_in.
module count_step_monitor #(
    parameter int unsigned WRAP_W    = 8,
    parameter int unsigned STALL_LIM = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    count_step_monitor_if.slave  bus
);
    localparam int unsigned STALL_W = $clog2(STALL_LIM + 1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         prev_q;
    logic               dir_d;
    logic [STALL_W-1:0] stall_cnt;
    logic [1:0]         delta;
    logic [STALL_W-1:0] stall_inc;

    // Step size modulo 4 and the saturating stall increment.
    always_comb begin
        delta     = bus.q_in - prev_q;
        stall_inc = (stall_cnt == STALL_W'(STALL_LIM)) ? stall_cnt
                                                       : stall_cnt + STALL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= INIT;
            prev_q       <= 2'd0;
            dir_d        <= 1'b0;
            stall_cnt    <= '0;
            bus.step_up  <= 1'b0;
            bus.step_dn  <= 1'b0;
            bus.wrap_up  <= 1'b0;
            bus.wrap_dn  <= 1'b0;
            bus.wrap_cnt <= '0;
            bus.stalled  <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= 2'b00;
        end else begin
            bus.step_up <= 1'b0;
            bus.step_dn <= 1'b0;
            bus.wrap_up <= 1'b0;
            bus.wrap_dn <= 1'b0;

            case (state)
                INIT: begin
                    prev_q <= bus.q_in;
                    dir_d  <= bus.up_down;
                    state  <= TRACK;
                end

                TRACK: begin
                    prev_q <= bus.q_in;
                    dir_d  <= bus.up_down;
                    if (delta == 2'd0) begin
                        stall_cnt   <= stall_inc;
                        bus.stalled <= (stall_inc == STALL_W'(STALL_LIM));
                    end else begin
                        stall_cnt   <= '0;
                        bus.stalled <= 1'b0;
                        // dir_d is the command the counter acted on this step.
                        if (delta == 2'd2) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'b01;
                            state        <= FAULT;
                        end else if ((delta == 2'd1) != dir_d) begin
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'b10;
                            state        <= FAULT;
                        end else if (delta == 2'd1) begin
                            bus.step_up <= 1'b1;
                            if (prev_q == 2'd3) begin
                                bus.wrap_up  <= 1'b1;
                                bus.wrap_cnt <= bus.wrap_cnt + WRAP_W'(1);
                            end
                        end else begin
                            bus.step_dn <= 1'b1;
                            if (prev_q == 2'd0) begin
                                bus.wrap_dn  <= 1'b1;
                                bus.wrap_cnt <= bus.wrap_cnt - WRAP_W'(1);
                            end
                        end
                    end
                end

                FAULT: begin
                    // Everything holds until software clears; wrap_cnt survives.
                    if (bus.clr_err) begin
                        bus.err      <= 1'b0;
                        bus.err_code <= 2'b00;
                        stall_cnt    <= '0;
                        bus.stalled  <= 1'b0;
                        state        <= INIT;
                    end
                end

                default: state <= INIT;
            endcase
        end
    end
endmodule
